// File: rtl/jpeg_cx_dc_huff_enc.sv
// Chroma DC Huffman encoder with byte packing and 0xFF byte stuffing.
// Each accepted signed DC difference becomes a category code followed by its
// magnitude bits. The bits are collected MSB-first into an accumulator and
// sent out as bytes. After every emitted 0xFF a 0x00 byte is inserted.
// A flush pads the last partial byte with 1s and then pulses flush_done_o.
//
// Ports:
//   clk_i, rst_i        clock and synchronous active-high reset
//   inlet_valid_i       a DC difference is presented
//   inlet_data_i        signed DC difference (two's complement)
//   inlet_flush_i       pad to a byte boundary after this transfer
//   inlet_accept_o      a transfer occurs when (valid | flush) & accept
//   outport_valid_o     an output byte is presented
//   outport_data_o      the entropy-coded byte
//   outport_accept_i    the byte is taken when valid & accept
//   flush_done_o        one-cycle pulse once a flush has completed
//   idle_o              idle, with no residual bits held
module jpeg_cx_dc_huff_enc #(
  parameter int unsigned DIFF_W = 12,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inlet_valid_i,
  input  logic [DIFF_W-1:0] inlet_data_i,
  input  logic              inlet_flush_i,
  output logic              inlet_accept_o,
  output logic              outport_valid_o,
  output logic [7:0]        outport_data_o,
  input  logic              outport_accept_i,
  output logic              flush_done_o,
  output logic              idle_o
);

  localparam int unsigned CNT_W = $clog2(ACC_W + 1);
  localparam int unsigned CAT_W = 4;
  localparam int unsigned PKT_W = 2 * (DIFF_W - 1);
  localparam logic [ACC_W-1:0] TOP_MASK = {8'hFF, {(ACC_W-8){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_STUFF,
    S_PAD
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               done_d;
  logic               resume_c;

  logic [DIFF_W-1:0]  sat_c;
  logic [DIFF_W-1:0]  abs_c;
  logic [DIFF_W-1:0]  mag_src_c;
  logic [DIFF_W-1:0]  mag_c;
  logic [DIFF_W-1:0]  code_c;
  logic [CAT_W-1:0]   cat_c;
  logic [CAT_W-1:0]   len_c;
  logic [CNT_W-1:0]   total_c;
  logic [PKT_W-1:0]   pkt_c;
  logic [CNT_W-1:0]   sh_c;
  logic [ACC_W-1:0]   acc_app_c;
  logic [ACC_W-1:0]   acc_pad_c;
  logic [7:0]         top_byte_c;
  logic               take_c;

  // Category, codeword and magnitude bits for the incoming difference
  always_comb begin
    sat_c = inlet_data_i;
    // -2048 has no 11-bit magnitude, so it is coded as -2047
    if (inlet_data_i == {1'b1, {(DIFF_W-1){1'b0}}}) begin
      sat_c = {1'b1, {(DIFF_W-2){1'b0}}, 1'b1};
    end
    abs_c = sat_c[DIFF_W-1] ? (~sat_c + DIFF_W'(1)) : sat_c;
    cat_c = '0;
    for (int i = 0; i < int'(DIFF_W); i++) begin
      if (abs_c[i]) cat_c = CAT_W'(i + 1);
    end
    // Negative values send the low bits of (diff - 1), i.e. the one's complement of |diff|
    mag_src_c = sat_c[DIFF_W-1] ? (sat_c - DIFF_W'(1)) : sat_c;
    mag_c     = mag_src_c & ((DIFF_W'(1) << cat_c) - DIFF_W'(1));
    if (cat_c < CAT_W'(3)) begin
      code_c = DIFF_W'(cat_c);
      len_c  = CAT_W'(2);
    end else begin
      // (cat-1) ones followed by a zero
      code_c = (DIFF_W'(1) << cat_c) - DIFF_W'(2);
      len_c  = cat_c;
    end
    total_c = CNT_W'(len_c) + CNT_W'(cat_c);
    pkt_c   = (PKT_W'(code_c) << cat_c) | PKT_W'(mag_c);
  end

  // Accumulator datapath: append below the residual bits, pad the top byte with 1s
  always_comb begin
    sh_c       = CNT_W'(ACC_W) - cnt_q - total_c;
    acc_app_c  = acc_q | (ACC_W'(pkt_c) << sh_c);
    acc_pad_c  = acc_q | (TOP_MASK & (TOP_MASK >> cnt_q));
    top_byte_c = acc_q[ACC_W-1 -: 8];
    take_c     = (inlet_valid_i | inlet_flush_i) & inlet_accept_o;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    resume_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take_c) begin
          if (inlet_valid_i) begin
            acc_d = acc_app_c;
            cnt_d = cnt_q + total_c;
          end
          if (inlet_flush_i) pend_d = 1'b1;
          if (cnt_d >= CNT_W'(8)) begin
            state_d = S_EMIT;
          end else if (inlet_flush_i) begin
            if (cnt_d == '0) begin
              // Already on a byte boundary: the flush completes at once
              done_d = 1'b1;
              pend_d = 1'b0;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end
      S_EMIT: begin
        if (outport_accept_i) begin
          acc_d = acc_q << 8;
          cnt_d = cnt_q - CNT_W'(8);
          if (top_byte_c == 8'hFF) state_d = S_STUFF;
          else                     resume_c = 1'b1;
        end
      end
      S_STUFF: begin
        if (outport_accept_i) resume_c = 1'b1;
      end
      S_PAD: begin
        if (cnt_q != '0) begin
          acc_d   = acc_pad_c;
          cnt_d   = CNT_W'(8);
          state_d = S_EMIT;
        end else begin
          done_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Where to go after a byte (and any stuff byte) has been taken.
    // When a pending flush lands on a byte boundary, done is raised here so that
    // it pulses in the cycle right after the last byte was accepted.
    if (resume_c) begin
      if (cnt_d >= CNT_W'(8)) begin
        state_d = S_EMIT;
      end else if (pend_q) begin
        if (cnt_d == '0) begin
          done_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_PAD;
        end
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      acc_q           <= '0;
      cnt_q           <= '0;
      pend_q          <= 1'b0;
      inlet_accept_o  <= 1'b1;
      outport_valid_o <= 1'b0;
      outport_data_o  <= '0;
      flush_done_o    <= 1'b0;
      idle_o          <= 1'b1;
    end else begin
      state_q         <= state_d;
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      pend_q          <= pend_d;
      inlet_accept_o  <= (state_d == S_IDLE) && (cnt_d < CNT_W'(8));
      outport_valid_o <= (state_d == S_EMIT) || (state_d == S_STUFF);
      outport_data_o  <= (state_d == S_EMIT) ? acc_d[ACC_W-1 -: 8] : 8'h00;
      flush_done_o    <= done_d;
      idle_o          <= (state_d == S_IDLE) && (cnt_d == '0);
    end
  end

endmodule
